// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: load/data bus and display outputs of the 7-segment scan driver
interface seg7_scan_driver_if #(parameter int NUM_DIGITS = 4);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digit_val;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   dp_val;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_done;
  modport master (output load, digit_val, digit_en, dp_val, blink_mask, input seg, dp, an, frame_done);
  modport slave (input load, digit_val, digit_en, dp_val, blink_mask, output seg, dp, an, frame_done);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed active-low 7-segment display scanner with shadow registers
// Ports: clock, reset (sync, active-high); bus (slave): load, digit_val, digit_en, dp_val,
// blink_mask in; seg, dp, an (active-low, registered) and frame_done pulse out.
// Optional blinking is compiled in with macro SEG7_BLINK_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input logic clock,
  input logic reset,
  seg7_scan_driver_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = $clog2(REFRESH_DIV);
  // abcdefg glyphs, value 0 in the low 7 bits
  localparam logic [111:0] GLYPHS = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001, 7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001};
  logic [SW-1:0]           scan_cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] val_s;
  logic [NUM_DIGITS-1:0]   en_s, dp_s, bm_s;
  logic                    blink_phase, visible, slot_end, last;
  logic [3:0]              cur;
  assign slot_end = scan_cnt == SW'(REFRESH_DIV - 1);
  assign last     = idx == IW'(NUM_DIGITS - 1);
  assign cur      = val_s[{idx, 2'b00} +: 4];
`ifdef SEG7_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  logic [BW-1:0] blink_cnt;
  always_ff @(posedge clock)
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      blink_cnt   <= blink_cnt == BW'(BLINK_DIV - 1) ? '0 : blink_cnt + 1'b1;
      blink_phase <= blink_phase ^ (blink_cnt == BW'(BLINK_DIV - 1));
    end
`else
  assign blink_phase = 1'b1;
`endif
  // with blink_phase stuck at 1 the mask term drops out
  assign visible = en_s[idx] & (blink_phase | ~bm_s[idx]);
  always_ff @(posedge clock)
    if (reset) begin
      scan_cnt       <= '0;
      idx            <= '0;
      val_s          <= '0;
      en_s           <= '0;
      dp_s           <= '0;
      bm_s           <= '0;
      bus.seg        <= '1;
      bus.dp         <= 1'b1;
      bus.an         <= '1;
      bus.frame_done <= 1'b0;
    end else begin
      scan_cnt <= slot_end ? '0 : scan_cnt + 1'b1;
      if (slot_end) idx <= last ? '0 : idx + 1'b1;
      if (bus.load) begin
        val_s <= bus.digit_val;
        en_s  <= bus.digit_en;
        dp_s  <= bus.dp_val;
        bm_s  <= bus.blink_mask;
      end
      bus.an         <= visible ? ~(NUM_DIGITS'(1) << idx) : '1;
      bus.seg        <= visible ? GLYPHS[7*cur +: 7] : '1;
      bus.dp         <= ~(visible & dp_s[idx]);
      bus.frame_done <= slot_end & last;
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed + random checks of seg7_scan_driver against a time-based model
module tb_seg7_scan_driver;
  localparam int N = 3, R = 4, B = 16;
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();
  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_DIV(B)) dut (.clock(clock), .reset(reset), .bus(bus));
  int errors = 0, checks = 0, e = 0;
  logic [11:0] sdv = '0;
  logic [2:0]  sen = '0, sdp = '0, sbm = '0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s e=%0d observed=%b expected=%b", tag, e, obs, exp);
    end
  endtask

  // one clock edge; model: outputs after edge e reflect shadow and time state after edge e-1
  task automatic step(input logic rst, input logic ld, input logic [11:0] dv,
                      input logic [2:0] en, input logic [2:0] dpi, input logic [2:0] bm);
    logic [11:0] pdv;
    logic [2:0]  pen, pdp, pbm, ean;
    logic [6:0]  eseg;
    logic        edp, efd, phase, vis;
    int          m, ix;
    reset = rst; bus.load = ld; bus.digit_val = dv; bus.digit_en = en; bus.dp_val = dpi; bus.blink_mask = bm;
    pdv = sdv; pen = sen; pdp = sdp; pbm = sbm;
    @(posedge clock);
    #1;
    if (rst) begin
      e = 0; sdv = '0; sen = '0; sdp = '0; sbm = '0;
      ean = '1; eseg = '1; edp = 1'b1; efd = 1'b0;
    end else begin
      if (ld) begin sdv = dv; sen = en; sdp = dpi; sbm = bm; end
      e++;
      m = e - 1;
      ix = (m / R) % N;
`ifdef SEG7_BLINK_EN
      phase = ((m / B) % 2) == 0;
`else
      phase = 1'b1;
`endif
      vis  = pen[ix] && !(pbm[ix] && !phase);
      ean  = vis ? ~(3'b001 << ix) : 3'b111;
      eseg = vis ? GLYPH[pdv[ix*4 +: 4]] : 7'h7f;
      edp  = vis ? ~pdp[ix] : 1'b1;
      efd  = (e % (R * N)) == 0;
    end
    chk("an", {5'b0, bus.an}, {5'b0, ean});
    chk("seg", {1'b0, bus.seg}, {1'b0, eseg});
    chk("dp", {7'b0, bus.dp}, {7'b0, edp});
    chk("frame_done", {7'b0, bus.frame_done}, {7'b0, efd});
  endtask

  // load=0 with junk on the data inputs: shadows must hold
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 12'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 12'hFFF, 3'b111, 3'b111, 3'b000);
    idle(25);
    step(1'b0, 1'b1, 12'h21F, 3'b111, 3'b010, 3'b000);
    idle(24);
    step(1'b0, 1'b1, 12'h21F, 3'b101, 3'b010, 3'b000);
    idle(13);
    for (int i = 0; i < R && (e % R) != R - 1; i++) idle(1);
    step(1'b0, 1'b1, 12'hA5C, 3'b111, 3'b101, 3'b000);
    idle(14);
    step(1'b0, 1'b1, 12'h987, 3'b111, 3'b000, 3'b001);
    idle(70);
    for (int i = 0; i < 200; i++)
      step(1'b0, $urandom_range(0, 5) == 0, 12'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
    step(1'b0, 1'b1, 12'h3E6, 3'b111, 3'b100, 3'b000);
    for (int i = 0; i < R * N && ((e / R) % N) != 2; i++) idle(1);
    step(1'b1, 1'b1, 12'h3E6, 3'b111, 3'b100, 3'b000);
    step(1'b0, 1'b1, 12'hB0D, 3'b111, 3'b001, 3'b010);
    idle(30);
    step(1'b1, 1'b0, 12'h000, 3'b000, 3'b000, 3'b000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clock cycles each digit is driven, minimum 2.
REQ-003 Parameter BLINK_DIV, default 25000000: clock cycles per blink half-period, minimum 2.
REQ-004 Port clock  input  1: single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port load  input  1: capture strobe for the shadow registers, sampled on every rising edge.
REQ-007 Port digit_val  input  4*NUM_DIGITS: hex value per digit; bits [4i+3:4i] belong to digit i.
REQ-008 Port digit_en  input  NUM_DIGITS: 1 = digit shown, 0 = digit blanked.
REQ-009 Port dp_val  input  NUM_DIGITS: 1 = decimal point lit for digit i.
REQ-010 Port blink_mask  input  NUM_DIGITS: 1 = digit i blinks.
REQ-011 Port seg  output  7: segments {a,b,c,d,e,f,g}, active-low, registered.
REQ-012 Port dp  output  1: decimal point, active-low, registered.
REQ-013 Port an  output  NUM_DIGITS: digit enables, active-low, one-cold, registered.
REQ-014 Port frame_done  output  1: one-cycle pulse when the last digit's slot ends.

Function
REQ-015 On an edge with load=1, the block shall copy digit_val, digit_en, dp_val and blink_mask into the shadow registers; with load=0 the shadow registers shall hold.
REQ-016 scan_cnt shall count 0..REFRESH_DIV-1 and wrap to 0; idx shall advance on the wrap edge, going from NUM_DIGITS-1 to 0.
REQ-017 Outputs shall be registered from (idx, shadow, blink_phase) with one-cycle latency; a shadow change at edge k shall appear on the outputs at edge k+1.
REQ-018 While digit idx is visible, an shall have only bit idx low, seg shall hold the glyph of shadow value idx, and dp shall be the inverse of shadow dp_val[idx].
REQ-019 Glyphs (abcdefg, active-low) shall be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-020 A digit is not visible when shadow digit_en[idx]=0, or (with blink compiled in) when blink_mask[idx]=1 and blink_phase=0.
REQ-021 For a digit that is not visible, the block shall drive an all ones, seg=1111111 and dp=1 during its slot; the scan timing is unchanged.
REQ-022 frame_done shall be high for exactly the one cycle after the edge where idx wraps from NUM_DIGITS-1 to 0.
REQ-023 If load=1 and a slot boundary occur on the same edge, the new idx shall use the newly loaded shadow data on the next edge.
REQ-024 With NUM_DIGITS=1, idx shall remain 0, an[0] shall follow visibility, and frame_done shall pulse on every scan_cnt wrap.

Reset
REQ-025 reset=1 shall clear scan_cnt, idx, the blink counter and all shadow registers to 0, and set blink_phase=1.
REQ-026 During reset, outputs shall be an all ones, seg=1111111, dp=1 and frame_done=0.
REQ-027 A reset asserted mid-frame shall override load and scan; scanning shall restart at digit 0 on the first edge after reset is released.

Configuration
REQ-028 With macro SEG7_BLINK_EN defined, blink_phase shall toggle every BLINK_DIV cycles and blink_mask shall take effect per REQ-020.
REQ-029 Without SEG7_BLINK_EN, no blink counter shall be built, blink_phase shall be constant 1, and blink_mask shall be ignored but remain a port.

Verification (NUM_DIGITS=3, REFRESH_DIV=4, BLINK_DIV=16)
REQ-030 Reset release with all shadows 0 -> an=111 and seg=1111111 for every cycle, with frame_done pulsing every 12 cycles.
REQ-031 load with digit_val=12'h21F, digit_en=111, dp_val=010 -> an cycles 110, 101, 011 at 4 cycles each; seg cycles 0111000 (F, dp=1), 1001111 (1, dp=0), 0010010 (2, dp=1).
REQ-032 digit_en=101 loaded -> digit 1 slot has an=111 and seg=1111111, while digits 0 and 2 are unchanged.
REQ-033 With SEG7_BLINK_EN and blink_mask=001 -> digit 0 is visible for 16 cycles, then blanked for 16 cycles, then repeats; without the macro, digit 0 is always visible.
REQ-034 reset pulsed while idx=2 -> outputs blank on the next edge; after release, digit 0 is shown first and the first frame_done occurs 12 cycles later.
REQ-035 load coinciding with a slot-boundary edge -> the next digit shows the new value one edge later, with no stale glyph.
